roi_integrator: RTL and testbench

ROI_INTEGRATOR -- requirements
Module: roi_integrator

---
 rtl/roi_integrator_pkg.sv | 22 ++
 rtl/roi_integrator_site_mapper.sv | 82 ++++++++
 rtl/roi_integrator.sv | 172 +++++++++++++++++
 tb/tb_roi_integrator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/roi_integrator_pkg.sv
// -----------------------------------------------------------------------------
// roi_integrator_pkg
// Shared project definitions for the ROI integrator slice:
//   COORD_WIDTH  - width of the pixel x/y coordinate buses
//   IMAGE_WIDTH  - nominal sensor width in pixels
//   IMAGE_HEIGHT - nominal sensor height in pixels
//   roi_state_e  - frame-level FSM states of the integrator
// -----------------------------------------------------------------------------
package roi_integrator_pkg;

    localparam int COORD_WIDTH  = 8;
    localparam int IMAGE_WIDTH  = 64;
    localparam int IMAGE_HEIGHT = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_DRAIN   = 2'd2,
        S_PUBLISH = 2'd3
    } roi_state_e;

endpackage : roi_integrator_pkg

// File: rtl/roi_integrator_site_mapper.sv
// -----------------------------------------------------------------------------
// roi_site_mapper
// Pipeline stage 1: maps a pixel coordinate to an ROI site index and decides
// whether the pixel lies inside that site's square ROI. All outputs are
// registered.
// Ports:
//   i_clk_500 / i_rst    clock, synchronous active-high reset
//   i_valid, i_data      qualified pixel (already gated by the caller)
//   i_x, i_y             pixel coordinates
//   o_valid, o_in_roi    registered qualifier and ROI hit flag
//   o_site, o_data       registered site index (row*GRID_N+col) and intensity
// -----------------------------------------------------------------------------
module roi_site_mapper
    import roi_integrator_pkg::*;
#(
    parameter int GRID_N   = 4,
    parameter int PITCH    = 16,
    parameter int ROI_SIZE = 8,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int SITE_W   = 4
) (
    input  logic                   i_clk_500,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [7:0]             i_data,
    input  logic [COORD_WIDTH-1:0] i_x,
    input  logic [COORD_WIDTH-1:0] i_y,
    output logic                   o_valid,
    output logic                   o_in_roi,
    output logic [SITE_W-1:0]      o_site,
    output logic [7:0]             o_data
);

    localparam int DW       = COORD_WIDTH + 2;      // one extra bit of headroom plus sign
    localparam int PITCH_LG = $clog2(PITCH);
    localparam int CW       = COORD_WIDTH + 1 - PITCH_LG;

    localparam logic signed [DW-1:0] ORG_X_C  = DW'(ORIGIN_X);
    localparam logic signed [DW-1:0] ORG_Y_C  = DW'(ORIGIN_Y);
    localparam logic [SITE_W-1:0]    GRID_C   = SITE_W'(GRID_N);

    logic signed [DW-1:0]  dx_s;
    logic signed [DW-1:0]  dy_s;
    logic [CW-1:0]         col_s;
    logic [CW-1:0]         row_s;
    logic [PITCH_LG-1:0]   off_x_s;
    logic [PITCH_LG-1:0]   off_y_s;
    logic                  in_roi_s;
    logic [SITE_W-1:0]     site_s;

    // Because PITCH is a power of two, the division and modulo are plain bit slices.
    assign dx_s    = $signed({2'b00, i_x}) - ORG_X_C;
    assign dy_s    = $signed({2'b00, i_y}) - ORG_Y_C;
    assign col_s   = dx_s[DW-2:PITCH_LG];
    assign row_s   = dy_s[DW-2:PITCH_LG];
    assign off_x_s = dx_s[PITCH_LG-1:0];
    assign off_y_s = dy_s[PITCH_LG-1:0];

    assign in_roi_s = !dx_s[DW-1] && !dy_s[DW-1]
                   && (32'(col_s) < GRID_N) && (32'(row_s) < GRID_N)
                   && (32'(off_x_s) < ROI_SIZE) && (32'(off_y_s) < ROI_SIZE);

    // Truncation is safe: the index is only used when in_roi_s guarantees range.
    assign site_s = SITE_W'(row_s) * GRID_C + SITE_W'(col_s);

    // Stage-1 pipeline register.
    always_ff @(posedge i_clk_500) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_in_roi <= 1'b0;
            o_site   <= '0;
            o_data   <= 8'd0;
        end else begin
            o_valid  <= i_valid;
            o_in_roi <= in_roi_s;
            o_site   <= site_s;
            o_data   <= i_data;
        end
    end

endmodule : roi_site_mapper

// File: rtl/roi_integrator.sv
// -----------------------------------------------------------------------------
// roi_integrator
// Integrates pixel intensity over a GRID_N x GRID_N array of square ROIs and
// publishes a per-site occupancy bitmap at the end of each frame.
// Ports:
//   i_clk_500, i_rst             clock, synchronous active-high reset
//   i_pixel_valid/_data/_x/_y    pixel stream
//   i_sync_fval                  frame valid (rising edge starts a frame)
//   i_frame_done                 end-of-frame pulse
//   o_occupancy                  bit r*GRID_N+c set when site (r,c) sum >= THRESHOLD
//   o_result_valid               one-cycle pulse when o_occupancy updates
//   o_frame_count                published frame counter (wraps)
//   o_overrun                    sticky: a pixel arrived outside S_ACCUM
// -----------------------------------------------------------------------------
module roi_integrator
    import roi_integrator_pkg::*;
#(
    parameter int GRID_N    = 4,
    parameter int PITCH     = 16,
    parameter int ROI_SIZE  = 8,
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0,
    parameter int THRESHOLD = 2000
) (
    input  logic                       i_clk_500,
    input  logic                       i_rst,
    input  logic                       i_pixel_valid,
    input  logic [7:0]                 i_pixel_data,
    input  logic [COORD_WIDTH-1:0]     i_pixel_x,
    input  logic [COORD_WIDTH-1:0]     i_pixel_y,
    input  logic                       i_sync_fval,
    input  logic                       i_frame_done,
    output logic [GRID_N*GRID_N-1:0]   o_occupancy,
    output logic                       o_result_valid,
    output logic [15:0]                o_frame_count,
    output logic                       o_overrun
);

    localparam int SITES  = GRID_N * GRID_N;
    localparam int SITE_W = (SITES > 1) ? $clog2(SITES) : 1;
    localparam int SUM_W  = 8 + 2 * $clog2(ROI_SIZE);

    roi_state_e             state_r;
    roi_state_e             state_nxt_s;
    logic                   drain_cnt_r;
    logic                   fval_d_r;
    logic [SUM_W-1:0]       sums_r [SITES];
    logic [SITES-1:0]       occupancy_r;
    logic                   result_valid_r;
    logic [15:0]            frame_count_r;
    logic                   overrun_r;

    logic                   fval_rise_s;
    logic                   accept_s;
    logic                   drop_s;
    logic                   clear_s;
    logic                   publish_s;
    logic                   map_valid_s;
    logic                   map_in_roi_s;
    logic [SITE_W-1:0]      map_site_s;
    logic [7:0]             map_data_s;

    // Saturating accumulate: sticks at all-ones instead of wrapping.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [7:0]       b);
        logic [SUM_W:0] t;
        t = {1'b0, a} + {{(SUM_W-7){1'b0}}, b};
        if (t[SUM_W]) begin
            return {SUM_W{1'b1}};
        end else begin
            return t[SUM_W-1:0];
        end
    endfunction

    assign fval_rise_s = i_sync_fval && !fval_d_r;
    assign accept_s    = i_pixel_valid && (state_r == S_ACCUM);
    assign drop_s      = i_pixel_valid && (state_r != S_ACCUM);
    // A rise in S_ACCUM aborts the running frame; S_PUBLISH clears after latching results.
    assign clear_s     = (fval_rise_s && (state_r == S_IDLE || state_r == S_ACCUM))
                      || (state_r == S_PUBLISH);
    // Results latch on the last drain cycle so o_result_valid is high during S_PUBLISH.
    assign publish_s   = (state_r == S_DRAIN) && drain_cnt_r;

    roi_site_mapper #(
        .GRID_N   (GRID_N),
        .PITCH    (PITCH),
        .ROI_SIZE (ROI_SIZE),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y),
        .SITE_W   (SITE_W)
    ) u_mapper (
        .i_clk_500 (i_clk_500),
        .i_rst     (i_rst),
        .i_valid   (accept_s),
        .i_data    (i_pixel_data),
        .i_x       (i_pixel_x),
        .i_y       (i_pixel_y),
        .o_valid   (map_valid_s),
        .o_in_roi  (map_in_roi_s),
        .o_site    (map_site_s),
        .o_data    (map_data_s)
    );

    // Next-state logic of the frame FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (fval_rise_s) state_nxt_s = S_ACCUM;
                else             state_nxt_s = S_IDLE;
            end
            S_ACCUM: begin
                if (fval_rise_s)       state_nxt_s = S_ACCUM;
                else if (i_frame_done) state_nxt_s = S_DRAIN;
                else                   state_nxt_s = S_ACCUM;
            end
            S_DRAIN: begin
                if (drain_cnt_r) state_nxt_s = S_PUBLISH;
                else             state_nxt_s = S_DRAIN;
            end
            S_PUBLISH: state_nxt_s = S_IDLE;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state, drain counter and frame-valid edge detector.
    always_ff @(posedge i_clk_500) begin
        if (i_rst) begin
            state_r     <= S_IDLE;
            drain_cnt_r <= 1'b0;
            fval_d_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= (state_r == S_DRAIN) ? !drain_cnt_r : 1'b0;
            fval_d_r    <= i_sync_fval;
        end
    end

    // Stage 2: per-site accumulators; a clear wins over a same-cycle update.
    always_ff @(posedge i_clk_500) begin
        if (i_rst || clear_s) begin
            for (int i = 0; i < SITES; i++) sums_r[i] <= '0;
        end else if (map_valid_s && map_in_roi_s) begin
            sums_r[map_site_s] <= sat_add(sums_r[map_site_s], map_data_s);
        end
    end

    // Published results and status flags.
    always_ff @(posedge i_clk_500) begin
        if (i_rst) begin
            occupancy_r    <= '0;
            result_valid_r <= 1'b0;
            frame_count_r  <= 16'd0;
            overrun_r      <= 1'b0;
        end else begin
            result_valid_r <= publish_s;
            if (publish_s) begin
                for (int i = 0; i < SITES; i++) begin
                    occupancy_r[i] <= (32'(sums_r[i]) >= THRESHOLD);
                end
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (drop_s) overrun_r <= 1'b1;
        end
    end

    assign o_occupancy    = occupancy_r;
    assign o_result_valid = result_valid_r;
    assign o_frame_count  = frame_count_r;
    assign o_overrun      = overrun_r;

endmodule : roi_integrator

// File: tb/tb_roi_integrator.sv
`timescale 1ns/1ps
module tb_roi_integrator;
    import roi_integrator_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   pv;
    logic [7:0]             pd;
    logic [COORD_WIDTH-1:0] px;
    logic [COORD_WIDTH-1:0] py;
    logic                   fval;
    logic                   fdone;
    logic [15:0]            occ;
    logic                   rv;
    logic [15:0]            fc;
    logic                   ovr;

    roi_integrator dut (
        .i_clk_500      (clk),
        .i_rst          (rst),
        .i_pixel_valid  (pv),
        .i_pixel_data   (pd),
        .i_pixel_x      (px),
        .i_pixel_y      (py),
        .i_sync_fval    (fval),
        .i_frame_done   (fdone),
        .o_occupancy    (occ),
        .o_result_valid (rv),
        .o_frame_count  (fc),
        .o_overrun      (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] occ;
        logic [15:0] cnt;
        logic        ovr;
        int          at;
    } exp_t;
    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rv === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("occupancy", 32'(occ), 32'(e.occ));
                chk("frame_count", 32'(fc), 32'(e.cnt));
                chk("overrun_at_publish", 32'(ovr), 32'(e.ovr));
                chk("result_valid_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] d);
        pv = 1'b1;
        px = COORD_WIDTH'(x);
        py = COORD_WIDTH'(y);
        pd = d;
        step();
        pv = 1'b0;
    endtask

    function automatic logic [7:0] val(input int kind, input int x, input int y);
        case (kind)
            0:       return 8'd40;
            1:       return 8'd30;
            2:       return (((x >= 32 && x <= 39) && (y >= 16 && y <= 23)) || x == 40 || x == 64)
                            ? 8'd255 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    task automatic push_exp(input logic [15:0] o, input logic [15:0] c, input logic v);
        exp_t e;
        e.occ = o;
        e.cnt = c;
        e.ovr = v;
        e.at  = cyc + 3;
        q.push_back(e);
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
            q.delete();
        end
        repeat (3) step();
    endtask

    task automatic run_frame(input int kind, input int width,
                             input logic [15:0] o, input logic [15:0] c, input logic v);
        fval = 1'b1;
        step();
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < width; x++) begin
                pix(x, y, val(kind, x, y));
            end
        end
        fdone = 1'b1;
        push_exp(o, c, v);
        step();
        fdone = 1'b0;
        fval  = 1'b0;
        wait_drained("frame");
    endtask

    initial begin
        rst = 1'b1; pv = 1'b0; pd = 8'd0; px = '0; py = '0; fval = 1'b0; fdone = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_occupancy", 32'(occ), 32'h0);
        chk("reset_frame_count", 32'(fc), 32'h0);
        chk("reset_overrun", 32'(ovr), 32'h0);
        chk("reset_result_valid", 32'(rv), 32'h0);

        // frame_done while idle must not produce a result
        fdone = 1'b1;
        step();
        fdone = 1'b0;
        repeat (6) step();
        chk("idle_frame_done_overrun", 32'(ovr), 32'h0);

        // uniform 40s: every site 2560
        run_frame(0, 64, 16'hFFFF, 16'd1, 1'b0);
        repeat (10) step();
        chk("occupancy_hold", 32'(occ), 32'hFFFF);

        // uniform 30s: every site 1920
        run_frame(1, 64, 16'h0000, 16'd2, 1'b0);

        // bright block at site (1,2), plus x=40 and x=64 columns that must not count
        run_frame(2, 65, 16'h0040, 16'd3, 1'b0);

        // site 0 at 1953, last pixel concurrent with frame_done lifts it to 2053;
        // a pixel one cycle later is dropped and flags overrun
        fval = 1'b1;
        step();
        for (int k = 0; k < 63; k++) pix(k % 8, k / 8, 8'd31);
        pv = 1'b1; px = COORD_WIDTH'(7); py = COORD_WIDTH'(7); pd = 8'd100;
        fdone = 1'b1;
        push_exp(16'h0001, 16'd4, 1'b1);
        step();
        fdone = 1'b0;
        px = COORD_WIDTH'(16); py = COORD_WIDTH'(0); pd = 8'd255;
        step();
        pv = 1'b0;
        fval = 1'b0;
        wait_drained("frame_concurrent");

        // overrun persists into the next frame; reset mid-frame discards it
        fval = 1'b1;
        step();
        chk("overrun_sticky", 32'(ovr), 32'h1);
        for (int k = 0; k < 100; k++) pix(k % 64, k / 64, 8'd40);
        rst = 1'b1;
        fval = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("midreset_occupancy", 32'(occ), 32'h0);
        chk("midreset_frame_count", 32'(fc), 32'h0);
        chk("midreset_overrun", 32'(ovr), 32'h0);
        repeat (6) step();
        run_frame(0, 64, 16'hFFFF, 16'd1, 1'b0);

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_roi_integrator
